hmmm_alu: RTL and testbench
===========================

// Module: hmmm_alu
// PURPOSE
//  Execute unit on the shared 16-bit tri-state data bus, downstream of register_file.
//  Latches operands A and B from the bus, then runs the selected op:
//   - ADD/SUB/NEG/COPY in a single cycle
//   - MUL/DIV/MOD iteratively
//  Drives the result back onto the bus for write-back into the register file.
//  The control FSM sequences reg_file_out/alu_*_in/alu_out so only one bus driver is active.
// PARAMETERS
//  WIDTH    16   datapath/bus width; all arithmetic is modulo 2^WIDTH, signed two's complement
//  ITER     16   iterations for MUL/DIV/MOD; must equal WIDTH
// PORTS
//  clk        in     1      rising-edge clock
//  rst        in     1      synchronous, active-high reset
//  alu_a_in   in     1      latch bus into operand A at the clock edge
//  alu_b_in   in     1      latch bus into operand B at the clock edge
//  alu_op     in     3      0 ADD, 1 SUB, 2 NEG, 3 MUL, 4 DIV, 5 MOD, 6 COPY, 7 reserved
//  start      in     1      begin op alu_op on latched A/B
//  alu_out    in     1      drive result onto data; otherwise data is high-Z from this block
//  data       inout  WIDTH  shared system bus
//  busy       out    1      iterative op in progress
//  done       out    1      one-cycle pulse: result register updated
//  div_zero   out    1      sticky; last DIV/MOD had B==0
// BEHAVIOUR
//  Reset:
//   - A=B=result=0; state IDLE; busy=0, done=0, div_zero=0
//   - any in-flight op is aborted; no done pulse follows
//  Operand latches:
//   - accepted only when busy==0; ignored while busy
//   - alu_a_in and alu_b_in may both be high in one cycle (both latch the same bus value)
//  FSM states: IDLE, ITER, FINISH
//   - IDLE --start & single-cycle op--> IDLE; result written at that edge; done=1 next cycle
//   - IDLE --start & MUL/DIV/MOD--> ITER; counter=0; busy=1
//   - ITER: one shift/add or shift/subtract per cycle; counter==ITER-1 --> FINISH
//   - FINISH: result written, busy=0, done=1, --> IDLE
//   - start while busy is ignored
//  Latency (start sampled at edge k):
//   - single-cycle ops: done high in cycle k+1
//   - MUL/DIV/MOD: busy high cycles k+1..k+16; done high in cycle k+17
//  Arithmetic:
//   - ADD A+B; SUB A-B; NEG -A; COPY A
//   - MUL: low WIDTH bits of A*B
//   - DIV/MOD floor semantics:
//       q = floor(A/B); r = A - q*B; r takes the sign of B (e.g. -7/2 = -4, -7 mod 2 = 1)
//       computed on magnitudes, then corrected: if signs differ and r_mag!=0 then q=-q_mag-1, r=B-...
//       i.e. apply the floor/sign fix-up so the identity above holds
//   - DIV -32768/-1 wraps to -32768
//   - B==0 on DIV/MOD: result=0, div_zero=1, still ITER cycles to done
//   - any other op clears div_zero
//   - op 7: result=0, single-cycle
//  Result register:
//   - held until the next done
//   - alu_out drives it even while busy (stale value); sequencing controller must wait for done
// CONFIGURATION
//  HMMM_ALU_DIV_EN
//   - defined: DIV/MOD implemented as above via hmmm_divider
//   - undefined: divider not instantiated; DIV/MOD behave as single-cycle with result=0
//     and div_zero=0; MUL unchanged
// STRUCTURE
//  Shared header hmmm_defines.vh:
//   - ALU op encodings (ALU_ADD..ALU_RSVD)
//   - bus width constant
//   - FSM state encodings
//  Sub-module hmmm_divider: unsigned restoring divider, one quotient bit per cycle
//   - interface: load, operand magnitudes in, q_mag/r_mag out
//  Multiplier shift-add and sign fix-up live in hmmm_alu
// TESTING
//  Latch A=5, B=3 with alu_op=ADD, start -> done in next cycle; alu_out drives 8; busy never 1
//  A=-7, B=2, DIV then MOD -> busy for 16 cycles, done at k+17; results -4 and 1
//  A=300, B=300, MUL -> result 0x5F90 (90000 mod 2^16); div_zero=0
//  A=9, B=0, DIV -> result 0, div_zero=1; following ADD clears div_zero
//  Start MUL, pulse start and alu_a_in at cycle k+5 -> both ignored, A unchanged;
//   assert rst at k+8 -> busy=0, result=0, no done pulse
//  alu_out=0 -> data reads Z from ALU side; DIV with macro undefined -> done at k+1, result 0

Source files
------------

// File: rtl/hmmm_alu_pkg.sv
// Shared definitions for the hmmm execute unit: bus width, ALU op codes,
// control FSM states and a two's-complement magnitude helper.
package hmmm_alu_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_NEG  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_DIV  = 3'd4,
    ALU_MOD  = 3'd5,
    ALU_COPY = 3'd6,
    ALU_RSVD = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  function automatic logic [BUS_W-1:0] mag(input logic [BUS_W-1:0] v);
    return v[BUS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/hmmm_alu_divider.sv
// Unsigned restoring divider: one quotient bit per step.
// Outputs show the step applied this cycle, so they are final on the last step.
module hmmm_alu_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_mag_i,
  input  logic [WIDTH-1:0] b_mag_i,
  output logic [WIDTH-1:0] q_mag_o,
  output logic [WIDTH-1:0] r_mag_o
);

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [WIDTH:0]   sh;
  logic             fit;

  always_comb begin
    sh      = {rem_q, quo_q[WIDTH-1]};
    fit     = (sh >= {1'b0, div_q});
    r_mag_o = fit ? (sh[WIDTH-1:0] - div_q) : sh[WIDTH-1:0];
    q_mag_o = {quo_q[WIDTH-2:0], fit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= a_mag_i;
      div_q <= b_mag_i;
    end else if (step_i) begin
      rem_q <= r_mag_o;
      quo_q <= q_mag_o;
    end
  end

endmodule

// File: rtl/hmmm_alu.sv
// hmmm execute unit on the shared tri-state bus.
// HMMM_ALU_DIV_EN enables iterative floor DIV/MOD via hmmm_alu_divider.
module hmmm_alu
  import hmmm_alu_pkg::*;
#(
  parameter int WIDTH = BUS_W,
  parameter int ITER  = BUS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_a_in,
  input  logic             alu_b_in,
  input  logic [2:0]       alu_op,
  input  logic             start,
  input  logic             alu_out,
  inout  wire  [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(ITER);
  typedef logic [WIDTH-1:0] w_t;

  alu_op_e       op, op_q;
  state_e        state_q;
  w_t            a_q, b_q, res_q;
  w_t            acc_q, mcand_q, mplier_q;
  w_t            quick, mul_nxt, div_res, bus_in;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, dz_q;
  logic          iter_op, launch;

  assign op      = alu_op_e'(alu_op);
  assign bus_in  = data;
  assign launch  = start && (state_q != S_ITER);
  assign mul_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef HMMM_ALU_DIV_EN
  assign iter_op = (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);

  w_t   q_mag, r_mag, q_fix, r_fix, r_tz;
  logic sdiff;

  hmmm_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk     (clk),
    .rst     (rst),
    .load_i  (launch && iter_op),
    .step_i  (state_q == S_ITER),
    .a_mag_i (mag(a_q)),
    .b_mag_i (mag(b_q)),
    .q_mag_o (q_mag),
    .r_mag_o (r_mag)
  );

  // Truncating result from magnitudes, then floor fix-up when signs differ
  always_comb begin
    sdiff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    r_tz  = a_q[WIDTH-1] ? -r_mag : r_mag;
    q_fix = sdiff ? -q_mag : q_mag;
    r_fix = r_tz;
    if (sdiff && (r_mag != '0)) begin
      q_fix = ~q_mag;
      r_fix = b_q + r_tz;
    end
    div_res = '0;
    if (b_q != '0) div_res = (op_q == ALU_DIV) ? q_fix : r_fix;
  end
`else
  assign iter_op = (op == ALU_MUL);
  assign div_res = '0;
`endif

  always_comb begin
    quick = '0;
    case (op)
      ALU_ADD:  quick = a_q + b_q;
      ALU_SUB:  quick = a_q - b_q;
      ALU_NEG:  quick = -a_q;
      ALU_COPY: quick = a_q;
      default:  quick = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (alu_a_in) a_q <= bus_in;
        if (alu_b_in) b_q <= bus_in;
      end
      unique case (state_q)
        S_IDLE, S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (start) begin
            op_q <= op;
            if (iter_op) begin
              state_q  <= S_ITER;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              acc_q    <= '0;
              mcand_q  <= a_q;
              mplier_q <= b_q;
            end else begin
              res_q  <= quick;
              done_q <= 1'b1;
              dz_q   <= 1'b0;
            end
          end
        end
        S_ITER: begin
          cnt_q    <= cnt_q + 1'b1;
          acc_q    <= mul_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= S_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= (op_q == ALU_MUL) ? mul_nxt : div_res;
            dz_q    <= (op_q != ALU_MUL) && (b_q == '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data     = alu_out ? res_q : 'z;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_hmmm_alu.sv
// Directed self-checking bench for hmmm_alu.
// DIV/MOD expectations follow HMMM_ALU_DIV_EN.
module tb_hmmm_alu;
  import hmmm_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_a_in = 1'b0;
  logic        alu_b_in = 1'b0;
  logic [2:0]  alu_op = 3'd0;
  logic        start = 1'b0;
  logic        alu_out = 1'b0;
  logic        tb_en = 1'b0;
  logic [15:0] tb_val = 16'h0;
  wire  [15:0] data;
  logic        busy, done, div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  assign data = tb_en ? tb_val : 'z;

  always #5 clk = ~clk;

  hmmm_alu dut (
    .clk      (clk),
    .rst      (rst),
    .alu_a_in (alu_a_in),
    .alu_b_in (alu_b_in),
    .alu_op   (alu_op),
    .start    (start),
    .alu_out  (alu_out),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic put(input logic [15:0] v, input logic la, input logic lb);
    @(negedge clk);
    tb_en = 1'b1; tb_val = v; alu_a_in = la; alu_b_in = lb;
    @(negedge clk);
    tb_en = 1'b0; alu_a_in = 1'b0; alu_b_in = 1'b0;
  endtask

  task automatic rd(output logic [15:0] v);
    @(negedge clk);
    alu_out = 1'b1;
    #1 v = data;
    alu_out = 1'b0;
  endtask

  // Leaves the caller 1 time unit after edge k (i.e. in cycle k+1)
  task automatic launch(input alu_op_e o);
    @(negedge clk);
    alu_op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 1; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL rst_dz got %b want 0", div_zero); end
    @(negedge clk); rst = 1'b0;
    rd(v);
    n_cmp++; if (v !== 16'h0) begin n_bad++; $display("FAIL rst_res got %h want 0000", v); end
  endtask

  task automatic test_add;
    logic [15:0] v;
    put(16'd5, 1'b1, 1'b0);
    put(16'd3, 1'b0, 1'b1);
    launch(ALU_ADD);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL add_done got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL add_busy got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_pulse got %b want 0", done); end
    rd(v);
    n_cmp++; if (v !== 16'd8) begin n_bad++; $display("FAIL add_res got %h want 0008", v); end
  endtask

  task automatic test_single_ops;
    logic [15:0] v;
    alu_op_e     ops [4] = '{ALU_SUB, ALU_NEG, ALU_COPY, ALU_RSVD};
    logic [15:0] exp [4] = '{16'h0002, 16'hFFFB, 16'h0005, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      launch(ops[i]);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL op%0d_done got %b want 1", i, done); end
      rd(v);
      n_cmp++; if (v !== exp[i]) begin n_bad++; $display("FAIL op%0d_res got %h want %h", i, v, exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    @(negedge clk);
    alu_op = ALU_ADD; start = 1'b1;
    @(negedge clk);
    alu_op = ALU_SUB;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", done); end
    rd(v);
    n_cmp++; if (v !== 16'd2) begin n_bad++; $display("FAIL b2b_res got %h want 0002", v); end
  endtask

  task automatic test_mul;
    logic [15:0] v;
    int lat, bc;
    put(16'd300, 1'b1, 1'b1);
    launch(ALU_MUL);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL mul_lat got %0d want 17", lat); end
    n_cmp++; if (bc !== 16) begin n_bad++; $display("FAIL mul_busy got %0d want 16", bc); end
    n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL mul_dz got %b want 0", div_zero); end
    rd(v);
    n_cmp++; if (v !== 16'h5F90) begin n_bad++; $display("FAIL mul_res got %h want 5f90", v); end
    put(16'hFFFD, 1'b1, 1'b0);
    put(16'd7, 1'b0, 1'b1);
    launch(ALU_MUL);
    wait_done(lat, bc);
    rd(v);
    n_cmp++; if (v !== 16'hFFEB) begin n_bad++; $display("FAIL mulneg_res got %h want ffeb", v); end
  endtask

  task automatic test_ignore_busy;
    logic [15:0] v;
    int lat, bc;
    put(16'd2, 1'b1, 1'b0);
    put(16'd3, 1'b0, 1'b1);
    launch(ALU_MUL);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_en = 1'b1; tb_val = 16'h1234; alu_a_in = 1'b1; alu_op = ALU_ADD; start = 1'b1;
    @(posedge clk); #1;
    tb_en = 1'b0; alu_a_in = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy got %b want 1", busy); end
    wait_done(lat, bc);
    n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL ign_lat got %0d want 13", lat); end
    rd(v);
    n_cmp++; if (v !== 16'd6) begin n_bad++; $display("FAIL ign_res got %h want 0006", v); end
    launch(ALU_COPY);
    rd(v);
    n_cmp++; if (v !== 16'd2) begin n_bad++; $display("FAIL ign_a got %h want 0002", v); end
  endtask

  task automatic test_abort;
    logic [15:0] v;
    int seen;
    put(16'd4, 1'b1, 1'b1);
    launch(ALU_MUL);
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    rd(v);
    n_cmp++; if (v !== 16'h0) begin n_bad++; $display("FAIL abort_res got %h want 0000", v); end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_bus_release;
    logic [15:0] v;
    put(16'd1, 1'b1, 1'b0);
    launch(ALU_NEG);
    @(negedge clk);
    tb_en = 1'b1; tb_val = 16'hA5A5; alu_out = 1'b0;
    #1 v = data;
    tb_en = 1'b0;
    n_cmp++; if (v !== 16'hA5A5) begin n_bad++; $display("FAIL bus_z got %h want a5a5", v); end
    rd(v);
    n_cmp++; if (v !== 16'hFFFF) begin n_bad++; $display("FAIL bus_drv got %h want ffff", v); end
  endtask

  task automatic test_div;
    logic [15:0] v;
    int lat, bc;
`ifdef HMMM_ALU_DIV_EN
    put(16'hFFF9, 1'b1, 1'b0);
    put(16'd2, 1'b0, 1'b1);
    launch(ALU_DIV);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL div_lat got %0d want 17", lat); end
    n_cmp++; if (bc !== 16) begin n_bad++; $display("FAIL div_busy got %0d want 16", bc); end
    rd(v);
    n_cmp++; if (v !== 16'hFFFC) begin n_bad++; $display("FAIL div_res got %h want fffc", v); end
    launch(ALU_MOD);
    wait_done(lat, bc);
    rd(v);
    n_cmp++; if (v !== 16'd1) begin n_bad++; $display("FAIL mod_res got %h want 0001", v); end
    put(16'h8000, 1'b1, 1'b0);
    put(16'hFFFF, 1'b0, 1'b1);
    launch(ALU_DIV);
    wait_done(lat, bc);
    rd(v);
    n_cmp++; if (v !== 16'h8000) begin n_bad++; $display("FAIL divwrap_res got %h want 8000", v); end
    put(16'd9, 1'b1, 1'b0);
    put(16'd0, 1'b0, 1'b1);
    launch(ALU_DIV);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL div0_lat got %0d want 17", lat); end
    n_cmp++; if (div_zero !== 1'b1) begin n_bad++; $display("FAIL div0_dz got %b want 1", div_zero); end
    rd(v);
    n_cmp++; if (v !== 16'h0) begin n_bad++; $display("FAIL div0_res got %h want 0000", v); end
    launch(ALU_ADD);
    n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL dzclr got %b want 0", div_zero); end
`else
    put(16'd9, 1'b1, 1'b0);
    put(16'd0, 1'b0, 1'b1);
    launch(ALU_ADD);
    rd(v);
    n_cmp++; if (v !== 16'd9) begin n_bad++; $display("FAIL pre_div got %h want 0009", v); end
    launch(ALU_DIV);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL div1_done got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL div1_busy got %b want 0", busy); end
    n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL div1_dz got %b want 0", div_zero); end
    rd(v);
    n_cmp++; if (v !== 16'h0) begin n_bad++; $display("FAIL div1_res got %h want 0000", v); end
    launch(ALU_ADD);
    launch(ALU_MOD);
    rd(v);
    n_cmp++; if (v !== 16'h0) begin n_bad++; $display("FAIL mod1_res got %h want 0000", v); end
    lat = 0; bc = 0;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_single_ops();
    test_back_to_back();
    test_mul();
    test_ignore_busy();
    test_div();
    test_bus_release();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
